// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read path: word type and skid-buffer sizing helper.
package fifo_pkg;

    localparam int unsigned DEF_FIFO_WIDTH = 16;

    typedef logic [DEF_FIFO_WIDTH-1:0] fifo_word_t;

    // Bits needed to hold an occupancy count of 0..depth.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus downstream valid/ready stream, grouped for the reader (master) and its peers.
interface fifo_stream_reader_if
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_FIFO_WIDTH
);
    logic             fifo_empty;
    logic             fifo_underflow;
    logic [WIDTH-1:0] fifo_data_out;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;

    modport master (
        input  fifo_empty, fifo_underflow, fifo_data_out, m_ready,
        output fifo_rd_en, m_data, m_valid
    );

    modport slave (
        output fifo_empty, fifo_underflow, fifo_data_out, m_ready,
        input  fifo_rd_en, m_data, m_valid
    );

endinterface

// File: rtl/fifo_rd_skid_buf.sv
// Circular output buffer: push on FIFO capture, pop on downstream handshake, head always presented.
module fifo_rd_skid_buf
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_FIFO_WIDTH,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CW   = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wrap_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= wrap_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (32'(count_q) == DEPTH)));

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master for the synchronous FIFO: issues reads, captures data one cycle later and
// streams it downstream in order, with a saturating delivered-word count and sticky underflow flag.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int unsigned SKID_DEPTH = 2,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    fifo_stream_reader_if.master bus,
    output logic [CNT_WIDTH-1:0] words_read,
    output logic                 err_underflow
);

    localparam int unsigned CW = cnt_width(SKID_DEPTH);

    logic                  valid;
    logic                  pop;
    logic                  rd_en;
    logic                  inflight_q;
    logic [CW-1:0]         count;
    logic [FIFO_WIDTH-1:0] head;
    logic [CNT_WIDTH-1:0]  words_q;
    logic                  err_q;
    int unsigned           occ;

    // Reserve a slot for every word already issued, crediting a slot freed by this cycle's pop.
    always_comb begin
        valid = (count != '0);
        pop   = valid && bus.m_ready;
        occ   = 32'(count) + 32'(inflight_q) - 32'(pop);
        rd_en = enable && !bus.fifo_empty && (occ < SKID_DEPTH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            words_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= rd_en;
            if (pop && (words_q != '1)) begin
                words_q <= words_q + 1'b1;
            end
            if (bus.fifo_underflow) begin
                err_q <= 1'b1;
            end
        end
    end

    fifo_rd_skid_buf #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data (bus.fifo_data_out),
        .pop       (pop),
        .count     (count),
        .head      (head)
    );

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = valid;
    assign bus.m_data     = head;
    assign words_read     = words_q;
    assign err_underflow  = err_q;

    no_rd_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !(rd_en && bus.fifo_empty));

    data_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (valid && !bus.m_ready) |=> (valid && $stable(head)));

    count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        32'(count) <= SKID_DEPTH);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO model feeds the reader, scoreboard checks the stream.
module tb_fifo_stream_reader;
    import fifo_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        m_ready;
    logic        wr_en;
    fifo_word_t  wr_data;
    logic        uf_force;
    logic [15:0] words_read;
    logic        err_underflow;

    fifo_word_t  fq[$];
    fifo_word_t  dout_q;
    logic        empty_q;
    logic        uf_q;

    fifo_word_t  exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          rd_cnt   = 0;
    int          pop_cnt  = 0;
    int          first_rd = -1;

    fifo_stream_reader_if #(.WIDTH(16)) bus ();

    fifo_stream_reader #(
        .FIFO_WIDTH (16),
        .SKID_DEPTH (2),
        .CNT_WIDTH  (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .bus           (bus),
        .words_read    (words_read),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign bus.fifo_empty     = empty_q;
    assign bus.fifo_data_out  = dout_q;
    assign bus.fifo_underflow = uf_q | uf_force;
    assign bus.m_ready        = m_ready;

    // Synchronous FIFO model sharing rst_n with the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fq.delete();
            dout_q  <= '0;
            uf_q    <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            uf_q <= 1'b0;
            if (bus.fifo_rd_en) begin
                if (fq.size() != 0) dout_q <= fq.pop_front();
                else uf_q <= 1'b1;
            end
            if (wr_en) fq.push_back(wr_data);
            empty_q <= (fq.size() == 0);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Stream monitor: every valid cycle must show the scoreboard head.
    always @(negedge clk) begin
        if (rst_n) begin
            check_eq("rd_en_while_empty", 32'(bus.fifo_rd_en & bus.fifo_empty), 0);
            if (bus.fifo_rd_en) begin
                rd_cnt++;
                if (first_rd < 0) first_rd = cyc;
            end
            if (bus.m_valid) begin
                if (exp_q.size() == 0) check_eq("stale_word", 32'(bus.m_valid), 0);
                else check_eq("m_data", 32'(bus.m_data), 32'(exp_q[0]));
                if (bus.m_ready) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    pop_cnt++;
                end
            end
        end
    end

    task automatic fifo_write(input fifo_word_t d);
        wr_en   = 1'b1;
        wr_data = d;
        exp_q.push_back(d);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!bus.m_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(bus.m_valid), 1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, exp_q.size(), 0);
    endtask

    task automatic check_burst(input string tag, input int len);
        for (int k = 0; k < len; k++) begin
            check_eq(tag, 32'(bus.m_valid && bus.m_ready), 1);
            @(negedge clk);
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        int rd0;
        int p0;
        int fv;
        rst_n    = 1'b0;
        enable   = 1'b0;
        m_ready  = 1'b0;
        wr_en    = 1'b0;
        wr_data  = '0;
        uf_force = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_m_valid", 32'(bus.m_valid), 0);
        check_eq("rst_m_data", 32'(bus.m_data), 0);
        check_eq("rst_words_read", 32'(words_read), 0);
        check_eq("rst_err", 32'(err_underflow), 0);
        check_eq("rst_rd_en", 32'(bus.fifo_rd_en), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic 8-word stream: latency and no bubbles.
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) fifo_write(fifo_word_t'(i));
        first_rd = -1;
        enable   = 1'b1;
        @(negedge clk);
        wait_valid("t1_first_valid");
        fv = cyc;
        check_eq("t1_latency", 32'(fv - first_rd), 2);
        check_burst("t1_no_bubble", 8);
        check_eq("t1_words_read", 32'(words_read), 8);

        // Full FIFO with backpressure: exactly two reads, head held.
        @(posedge clk);
        #1;
        enable  = 1'b0;
        m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) fifo_write(fifo_word_t'(i));
        rd0    = rd_cnt;
        enable = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_eq("t2_rd_pulses", 32'(rd_cnt - rd0), 2);
        check_eq("t2_held_valid", 32'(bus.m_valid), 1);
        check_eq("t2_held_data", 32'(bus.m_data), 32'h0001);
        @(posedge clk);
        #1 m_ready = 1'b1;
        @(negedge clk);
        check_burst("t2_no_gap", 8);
        check_eq("t2_drained", exp_q.size(), 0);

        // Toggling ready with continuous feed.
        p0 = pop_cnt;
        for (int i = 0; i < 16; i++) begin
            m_ready = (i % 2 == 0);
            fifo_write(fifo_word_t'(16'h0100 + i));
        end
        m_ready = 1'b1;
        drain("t3_drain");
        check_eq("t3_pops", 32'(pop_cnt - p0), 16);

        // Enable dropped one cycle after a read.
        enable = 1'b0;
        for (int i = 0; i < 4; i++) fifo_write(fifo_word_t'(16'h0200 + i));
        rd0    = rd_cnt;
        p0     = pop_cnt;
        enable = 1'b1;
        @(posedge clk);
        #1 enable = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("t4_one_read", 32'(rd_cnt - rd0), 1);
        check_eq("t4_inflight_delivered", 32'(pop_cnt - p0), 1);
        enable = 1'b1;
        drain("t4_resume_drain");
        check_eq("t4_total_reads", 32'(rd_cnt - rd0), 4);
        check_eq("t4_total_pops", 32'(pop_cnt - p0), 4);

        // Async reset with two words buffered.
        @(posedge clk);
        #1;
        enable  = 1'b0;
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) fifo_write(fifo_word_t'(16'h0300 + i));
        enable = 1'b1;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_eq("t5_rst_valid", 32'(bus.m_valid), 0);
        check_eq("t5_rst_words", 32'(words_read), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m_ready = 1'b1;
        p0      = pop_cnt;
        repeat (6) @(negedge clk);
        check_eq("t5_no_stale_pops", 32'(pop_cnt - p0), 0);
        check_eq("t5_no_stale_valid", 32'(bus.m_valid), 0);
        @(posedge clk);
        #1;
        fifo_write(16'h0400);
        fifo_write(16'h0401);
        drain("t5_resume_drain");
        check_eq("t5_resume_pops", 32'(pop_cnt - p0), 2);

        // Sticky underflow.
        @(posedge clk);
        #1 uf_force = 1'b1;
        @(posedge clk);
        #1 uf_force = 1'b0;
        @(negedge clk);
        check_eq("t6_err_set", 32'(err_underflow), 1);
        repeat (5) @(negedge clk);
        check_eq("t6_err_sticky", 32'(err_underflow), 1);

        // Saturate words_read: 2 already counted, push past 0xFFFF.
        @(posedge clk);
        #1;
        p0 = pop_cnt;
        for (int i = 0; i < 65536; i++) fifo_write(fifo_word_t'(i));
        drain("t6_sat_drain");
        check_eq("t6_sat_pops", 32'(pop_cnt - p0), 65536);
        check_eq("t6_words_sat", 32'(words_read), 32'hFFFF);
        check_eq("t6_err_still", 32'(err_underflow), 1);

        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_eq("t6_err_cleared", 32'(err_underflow), 0);
        check_eq("t6_words_cleared", 32'(words_read), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
